// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix datapath types, defaults and slot helpers
// Purpose: default dimensions/width, unloader state encoding, packed-slot offset helper.
// Ports: none (package).
package matrix_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_ROWS   = 2;
  localparam int DEFAULT_NUM_COLS   = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } unloader_state_t;

  // Element k of a packed row-major matrix sits top-down: element 0 at the MSBs.
  function automatic int slot_offset(input int k, input int n, input int dw);
    return (n - 1 - k) * dw;
  endfunction

  // Index width for a dimension; a single-entry dimension still gets one bit.
  function automatic int dim_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_unloader_if.sv
// rtl/matrix_result_unloader_if.sv - tagged element stream interface
// Purpose: one matrix element per transfer with row/col tags and a last marker.
// Ports: data, row, col, last, valid driven by master; ready driven by slave.
interface matrix_result_unloader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_W      = 1,
  parameter int COL_W      = 1
);
  logic [DATA_WIDTH-1:0] data;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, row, col, last, valid, input ready);
  modport slave  (input data, row, col, last, valid, output ready);
endinterface

// File: rtl/matrix_index_counter.sv
// rtl/matrix_index_counter.sv - row/col/linear index walker over a matrix
// Purpose: steps a linear index with matching row/col, wraps to 0 after the last element.
// Ports: clk, rst (async high), clear (force to 0), advance (step one element),
//        index/row/col (current position), last (index is the final element).
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS,
  parameter int NUM_COLS = DEFAULT_NUM_COLS
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clear,
  input  logic                                      advance,
  output logic [dim_width(NUM_ROWS*NUM_COLS)-1:0]   index,
  output logic [dim_width(NUM_ROWS)-1:0]            row,
  output logic [dim_width(NUM_COLS)-1:0]            col,
  output logic                                      last
);

  localparam int N     = NUM_ROWS * NUM_COLS;
  localparam int IDX_W = dim_width(N);
  localparam int ROW_W = dim_width(NUM_ROWS);
  localparam int COL_W = dim_width(NUM_COLS);

  assign last = (index == IDX_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
      row   <= '0;
      col   <= '0;
    end else if (clear || (advance && last)) begin
      index <= '0;
      row   <= '0;
      col   <= '0;
    end else if (advance) begin
      index <= index + IDX_W'(1);
      if (col == COL_W'(NUM_COLS - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_result_unloader.sv
// rtl/matrix_result_unloader.sv - captures a multiplier result and streams its elements
// Purpose: four-phase capture of the packed result, then one tagged element per transfer.
// Ports: clk, rst (async high), Out (packed row-major result), out_ready (result valid),
//        out_ack (acknowledge), elem (tagged element stream, master side).
module matrix_result_unloader
  import matrix_pkg::*;
#(
  parameter int NUM_ROWS   = DEFAULT_NUM_ROWS,
  parameter int NUM_COLS   = DEFAULT_NUM_COLS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_ROWS*NUM_COLS*DATA_WIDTH-1:0] Out,
  input  logic                                 out_ready,
  output logic                                 out_ack,
  matrix_result_unloader_if.master             elem
);

  localparam int N     = NUM_ROWS * NUM_COLS;
  localparam int IDX_W = dim_width(N);
  localparam int ROW_W = dim_width(NUM_ROWS);
  localparam int COL_W = dim_width(NUM_COLS);

  unloader_state_t             state;
  logic [N*DATA_WIDTH-1:0]     buffer;
  logic                        valid_q;
  logic [IDX_W-1:0]            index;
  logic [ROW_W-1:0]            row;
  logic [COL_W-1:0]            col;
  logic                        idx_last;
  logic                        capture;
  logic                        transfer;
  logic [DATA_WIDTH-1:0]       elems [N];
  logic [DATA_WIDTH-1:0]       cur_data;

  // Capture only once the previous ack has been released, so a result held
  // high across a finished stream is never emitted twice.
  assign capture  = (state == ST_IDLE) && out_ready && !out_ack;
  assign transfer = (state == ST_STREAM) && valid_q && elem.ready;

  matrix_index_counter #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (capture),
    .advance (transfer),
    .index   (index),
    .row     (row),
    .col     (col),
    .last    (idx_last)
  );

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign elems[k] = buffer[slot_offset(k, N, DATA_WIDTH) +: DATA_WIDTH];
  end

  always_comb begin
    cur_data = '0;
    for (int k = 0; k < N; k++) begin
      if (index == IDX_W'(k)) cur_data = elems[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      out_ack <= 1'b0;
      valid_q <= 1'b0;
      buffer  <= '0;
    end else begin
      // Ack release runs regardless of state so it can overlap the stream.
      if (out_ack && !out_ready) out_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (capture) begin
            buffer  <= Out;
            out_ack <= 1'b1;
            valid_q <= 1'b1;
            state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (transfer && idx_last) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign elem.data  = cur_data;
  assign elem.row   = row;
  assign elem.col   = col;
  assign elem.valid = valid_q;
  assign elem.last  = valid_q && idx_last;

endmodule

// File: tb/tb_matrix_result_unloader.sv
// tb/tb_matrix_result_unloader.sv - scoreboard bench for matrix_result_unloader
module tb_matrix_result_unloader;
  import matrix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] out_a;
  logic         rdy_a, ack_a;
  logic [191:0] out_b;
  logic         rdy_b, ack_b;

  matrix_result_unloader_if #(.DATA_WIDTH(32), .ROW_W(1), .COL_W(1)) elem_a ();
  matrix_result_unloader_if #(.DATA_WIDTH(32), .ROW_W(1), .COL_W(2)) elem_b ();

  matrix_result_unloader #(.NUM_ROWS(2), .NUM_COLS(2), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .Out(out_a), .out_ready(rdy_a), .out_ack(ack_a), .elem(elem_a.master)
  );
  matrix_result_unloader #(.NUM_ROWS(2), .NUM_COLS(3), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .Out(out_b), .out_ready(rdy_b), .out_ack(ack_b), .elem(elem_b.master)
  );

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    logic        last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [127:0] v);
    for (int k = 0; k < 4; k++)
      q_a.push_back('{v[(3-k)*32 +: 32], k / 2, k % 2, (k == 3)});
  endtask

  task automatic push_b(input logic [191:0] v);
    for (int k = 0; k < 6; k++)
      q_b.push_back('{v[(5-k)*32 +: 32], k / 3, k % 3, (k == 5)});
  endtask

  task automatic wait_done_a(input string tag);
    int i = 0;
    while ((elem_a.valid || q_a.size() != 0) && i < 40) begin
      step();
      i++;
    end
    check({tag, "_valid_low"}, elem_a.valid, 1'b0);
    check({tag, "_all_seen"}, q_a.size(), 0);
  endtask

  task automatic wait_done_b(input string tag);
    int i = 0;
    while ((elem_b.valid || q_b.size() != 0) && i < 40) begin
      step();
      i++;
    end
    check({tag, "_valid_low"}, elem_b.valid, 1'b0);
    check({tag, "_all_seen"}, q_b.size(), 0);
  endtask

  // Scoreboard monitors: sample mid-cycle; a valid&&ready seen here is the
  // transfer taken at the next rising edge.
  logic        stall_a = 1'b0;
  logic [31:0] hd_a;
  logic        hr_a, hc_a, hl_a;
  always @(negedge clk) begin
    if (stall_a) begin
      check("stall_valid", elem_a.valid, 1'b1);
      check("stall_data", elem_a.data, hd_a);
      check("stall_row", elem_a.row, hr_a);
      check("stall_col", elem_a.col, hc_a);
      check("stall_last", elem_a.last, hl_a);
    end
    if (elem_a.valid && elem_a.ready) begin
      check("a_expected_elem", (q_a.size() != 0), 1'b1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check("a_data", elem_a.data, e_a.data);
        check("a_row", elem_a.row, e_a.row[0]);
        check("a_col", elem_a.col, e_a.col[0]);
        check("a_last", elem_a.last, e_a.last);
      end
    end
    stall_a = elem_a.valid && !elem_a.ready;
    hd_a = elem_a.data;
    hr_a = elem_a.row;
    hc_a = elem_a.col;
    hl_a = elem_a.last;
  end

  always @(negedge clk) begin
    if (elem_b.valid && elem_b.ready) begin
      check("b_expected_elem", (q_b.size() != 0), 1'b1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check("b_data", elem_b.data, e_b.data);
        check("b_row", elem_b.row, e_b.row[0]);
        check("b_col", elem_b.col, e_b.col[1:0]);
        check("b_last", elem_b.last, e_b.last);
      end
    end
  end

  logic [127:0] mat_a;
  logic [6:0]   pat;

  initial begin
    rst = 1'b1;
    out_a = '0; rdy_a = 1'b0; elem_a.ready = 1'b0;
    out_b = '0; rdy_b = 1'b0; elem_b.ready = 1'b0;
    step();
    check("rst_ack", ack_a, 1'b0);
    check("rst_valid", elem_a.valid, 1'b0);
    check("rst_last", elem_a.last, 1'b0);
    check("rst_data", elem_a.data, 32'h0);
    check("rst_row", elem_a.row, 1'b0);
    check("rst_col", elem_a.col, 1'b0);
    step();
    rst = 1'b0;
    step();

    // 1: back-to-back stream of [1 2;3 4]x[1 3;2 4]
    mat_a = 128'h40A00000_41300000_41300000_41C80000;
    out_a = mat_a; push_a(mat_a);
    rdy_a = 1'b1; elem_a.ready = 1'b1;
    step();
    check("t1_ack_rise", ack_a, 1'b1);
    check("t1_valid_rise", elem_a.valid, 1'b1);
    check("t1_first_data", elem_a.data, 32'h40A00000);
    repeat (4) step();
    check("t1_b2b_valid_low", elem_a.valid, 1'b0);
    check("t1_b2b_all_seen", q_a.size(), 0);
    rdy_a = 1'b0;
    step();
    check("t1_ack_fall", ack_a, 1'b0);

    // 2: stalled stream, then 3: result held high across finished stream
    push_a(mat_a);
    rdy_a = 1'b1;
    step();
    pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
    for (int i = 0; i < 7; i++) begin
      elem_a.ready = pat[i];
      step();
    end
    elem_a.ready = 1'b1;
    check("t2_valid_low", elem_a.valid, 1'b0);
    check("t2_all_seen", q_a.size(), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_ack_held", ack_a, 1'b1);
      check("t3_no_restream", elem_a.valid, 1'b0);
    end
    rdy_a = 1'b0;
    step();
    check("t3_ack_fall", ack_a, 1'b0);
    mat_a = {4{32'h3F800000}};
    out_a = mat_a; push_a(mat_a);
    rdy_a = 1'b1;
    step();
    check("t3_ack_second", ack_a, 1'b1);
    wait_done_a("t3_second");
    rdy_a = 1'b0;
    step();

    // 4: ack released mid-stream
    mat_a = 128'h3F800000_40000000_40400000_40800000;
    out_a = mat_a; push_a(mat_a);
    rdy_a = 1'b1;
    step();
    check("t4_ack_rise", ack_a, 1'b1);
    rdy_a = 1'b0;
    step();
    check("t4_ack_fall_midstream", ack_a, 1'b0);
    check("t4_still_streaming", elem_a.valid, 1'b1);
    wait_done_a("t4");

    // 5: reset after the second transfer
    mat_a = 128'h11111111_22222222_33333333_44444444;
    out_a = mat_a; push_a(mat_a);
    rdy_a = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5_rst_ack", ack_a, 1'b0);
    check("t5_rst_valid", elem_a.valid, 1'b0);
    check("t5_rst_index", dut_a.u_counter.index, 2'd0);
    check("t5_two_delivered", q_a.size(), 2);
    q_a.delete();
    step();
    rst = 1'b0;
    push_a(mat_a);
    step();
    check("t5_recapture_ack", ack_a, 1'b1);
    check("t5_recapture_valid", elem_a.valid, 1'b1);
    check("t5_restart_row", elem_a.row, 1'b0);
    check("t5_restart_col", elem_a.col, 1'b0);
    wait_done_a("t5");
    rdy_a = 1'b0;
    step();

    // 6: 2x3 matrix of 1.0..6.0
    out_b = {32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000};
    push_b(out_b);
    rdy_b = 1'b1; elem_b.ready = 1'b1;
    step();
    check("t6_ack_rise", ack_b, 1'b1);
    wait_done_b("t6");
    rdy_b = 1'b0;
    step();
    check("t6_ack_fall", ack_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
